// File: rtl/bitwise_pkg.sv
// Shared types for the bit-serial bit-wise unit: opcode and FSM state encodings.
package bitwise_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOT  = 3'd0,
      OP_AND  = 3'd1,
      OP_OR   = 3'd2,
      OP_XOR  = 3'd3,
      OP_NAND = 3'd4,
      OP_NOR  = 3'd5,
      OP_XNOR = 3'd6,
      OP_BUF  = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bitwise_logic_cell.sv
// One-bit bit-wise function of (op, a_i, b_i); also the reference cell for the parallel gates.
module bitwise_logic_cell
   import bitwise_pkg::*;
(
   input  op_t  op,
   input  logic a_i,
   input  logic b_i,
   output logic y
);

   always_comb begin
      y = 1'b0;
      unique case (op)
         OP_NOT:  y = ~a_i;
         OP_AND:  y = a_i & b_i;
         OP_OR:   y = a_i | b_i;
         OP_XOR:  y = a_i ^ b_i;
         OP_NAND: y = ~(a_i & b_i);
         OP_NOR:  y = ~(a_i | b_i);
         OP_XNOR: y = ~(a_i ^ b_i);
         OP_BUF:  y = a_i;
         default: y = 1'b0;
      endcase
   end

endmodule

// File: rtl/bit_serial_bitwise_unit.sv
// Bit-serial bit-wise unit: captures two operands, evaluates one result bit per clock
// LSB first, then presents the full result over a valid/ready handshake.
module bit_serial_bitwise_unit
   import bitwise_pkg::*;
#(
   parameter int N = 8
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] c,
   output logic         busy
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   state_t        state_q, state_d;
   op_t           op_q, op_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [N-1:0]  c_q, c_d;
   logic [CW-1:0] idx_q, idx_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          busy_q, busy_d;
   logic          bit_res;
   logic          last_bit;

   assign last_bit = (idx_q == CW'(N - 1));

   bitwise_logic_cell u_cell (
      .op  (op_q),
      .a_i (a_q[idx_q]),
      .b_i (b_q[idx_q]),
      .y   (bit_res)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      idx_d   = idx_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d     = a;
               b_d     = b;
               op_d    = op_t'(op);
               c_d     = '0;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Bits above idx stay 0 until their turn, so c always shows a clean partial result.
            c_d[idx_q] = bit_res;
            if (last_bit) begin
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + CW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Handshake outputs are registered from the next state so they line up with state_q.
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= OP_NOT;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         idx_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         idx_q       <= idx_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign c         = c_q;

endmodule

// File: tb/tb_bit_serial_bitwise_unit.sv
// Directed and sweep bench for bit_serial_bitwise_unit with N=8.
module tb_bit_serial_bitwise_unit;

   localparam int N = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] c;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   bit_serial_bitwise_unit #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] model(input logic [2:0] o, input logic [N-1:0] x,
                                          input logic [N-1:0] y);
      case (o)
         3'd0:    return ~x;
         3'd1:    return x & y;
         3'd2:    return x | y;
         3'd3:    return x ^ y;
         3'd4:    return ~(x & y);
         3'd5:    return ~(x | y);
         3'd6:    return ~(x ^ y);
         default: return x;
      endcase
   endfunction

   // Waits for in_ready, issues one op, scrambles inputs after accept, and checks the
   // bit-serial progression up to the first cycle out_valid is high. Leaves the unit in DONE.
   task automatic run_op(input logic [2:0] o, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input bit partial);
      logic [N-1:0] e;
      logic [N-1:0] mask;
      e = model(o, av, bv);
      @(negedge clk);
      for (int w = 0; w < 50 && !in_ready; w++) @(negedge clk);
      if (!in_ready) chk("ready_timeout", in_ready, 1'b1);
      op = o; a = av; b = bv; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a = N'($urandom);
      b = N'($urandom);
      for (int k = 0; k <= N; k++) begin
         if (k > 0) @(negedge clk);
         mask = (k >= N) ? '1 : N'((64'd1 << k) - 64'd1);
         if (k == N) begin
            chk("latency_valid_hi", out_valid, 1'b1);
            chk("result", c, e);
            chk("done_in_ready", in_ready, 1'b0);
         end else if (k == N - 1 || partial) begin
            chk("run_valid_lo", out_valid, 1'b0);
            if (partial) chk("partial_c", c, e & mask);
         end
      end
   endtask

   logic [2:0]   bb_op [3];
   logic [N-1:0] bb_a  [3];
   logic [N-1:0] bb_b  [3];
   logic [N-1:0] bb_e  [3];
   int           t_acc [3];

   initial begin
      rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_c", c, '0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;

      // NOT ignores b
      run_op(3'd0, 8'hA5, 8'hFF, 1'b1);
      chk("not_c", c, 8'h5A);
      @(negedge clk);
      chk("not_idle_ready", in_ready, 1'b1);
      chk("not_held_c", c, 8'h5A);
      chk("not_idle_busy", busy, 1'b0);

      // Back-to-back with in_valid held and out_ready high
      bb_op[0] = 3'd1; bb_a[0] = 8'hF0; bb_b[0] = 8'h3C; bb_e[0] = 8'h30;
      bb_op[1] = 3'd3; bb_a[1] = 8'hFF; bb_b[1] = 8'h0F; bb_e[1] = 8'hF0;
      bb_op[2] = 3'd6; bb_a[2] = 8'h00; bb_b[2] = 8'h00; bb_e[2] = 8'hFF;
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("b2b_ready", in_ready, 1'b1);
         op = bb_op[i]; a = bb_a[i]; b = bb_b[i];
         @(negedge clk);
         t_acc[i] = cyc;
         for (int w = 0; w < 40 && !out_valid; w++) @(negedge clk);
         chk("b2b_valid", out_valid, 1'b1);
         chk("b2b_c", c, bb_e[i]);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("b2b_gap01", t_acc[1] - t_acc[0], N + 2);
      chk("b2b_gap12", t_acc[2] - t_acc[1], N + 2);

      // Backpressure on OR
      out_ready = 1'b0;
      run_op(3'd2, 8'h81, 8'h18, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 1'b1);
         chk("bp_c", c, 8'h99);
         chk("bp_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", out_valid, 1'b0);
      chk("bp_release_ready", in_ready, 1'b1);
      chk("bp_release_busy", busy, 1'b0);
      chk("bp_release_c", c, 8'h99);

      // Captured operands are used even though a changes after accept
      run_op(3'd4, 8'hFF, 8'h0F, 1'b1);
      chk("nand_c", c, 8'hF0);
      @(negedge clk);

      // Reset in the middle of a NOR
      op = 3'd5; a = 8'h00; b = 8'h00; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("nor_partial", c, 8'h07);
      rst = 1'b1;
      #1;
      chk("midrst_c", c, '0);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      run_op(3'd7, 8'h3C, 8'hA5, 1'b1);
      chk("buf_c", c, 8'h3C);

      // Sweep of all opcodes with random operands
      for (int i = 0; i < 1000; i++) begin
         run_op(3'(i % 8), N'($urandom), N'($urandom), 1'b1);
      end
      @(negedge clk);
      chk("sweep_end_ready", in_ready, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
